// File: rtl/seg7_pkg.sv
// Shared segment patterns for the scanned 7-segment display.
// All patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_scan_display_bcd_to_seg7.sv
// Combinational BCD to active-low 7-segment decoder.
// Codes 10..15 are not BCD and show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: give every always_comb output a value before any branch so no latch is inferred.
    seg = SEG_DASH;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexes DIGITS packed BCD digits onto one common-anode 7-segment bank.
// It latches the digit data at frame boundaries so the display does not tear, and it can blank leading zeros.
module seg7_scan_display
  import seg7_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 4
) (
  input  logic                  clk,
  input  logic                  r_n,
  input  logic                  en,
  input  logic                  blank_lz,
  input  logic [4*DIGITS-1:0]   data,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  frame_done
);

  localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] snap_q, snap_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic [6:0]          seg_q, seg_d;

  logic                tick;
  logic                frame_end;
  logic [DIGITS-1:0]   upper_zero;
  logic [3:0]          cur_digit;
  logic                lz_blank;
  logic [6:0]          cur_seg;

  assign tick       = en && (pre_q == PRE_LAST);
  assign frame_end  = tick && (idx_q == IDX_LAST);
  assign frame_done = frame_end;

  // upper_zero[i]: snapshot digits i..DIGITS-1 are all zero (invalid codes count as nonzero)
  always_comb begin
    upper_zero             = '0;
    upper_zero[DIGITS-1]   = (snap_q[4*(DIGITS-1) +: 4] == 4'd0);
    for (int i = DIGITS - 2; i >= 0; i--) begin
      upper_zero[i] = upper_zero[i+1] && (snap_q[4*i +: 4] == 4'd0);
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    lz_blank  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_digit = snap_q[4*i +: 4];
        lz_blank  = blank_lz && (i != 0) && upper_zero[i];
      end
    end
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  always_comb begin
    pre_d  = pre_q;
    idx_d  = idx_q;
    snap_d = snap_q;
    if (en) begin
      pre_d = tick ? '0 : pre_q + PRE_W'(1);
    end
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end
    if (frame_end) begin
      snap_d = data;
    end
  end

  // A blanked slot still uses its full SCAN_DIV cycles; only the outputs go dark.
  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    if (en && !lz_blank) begin
      an_d  = ~(DIGITS'(1) << idx_q);
      seg_d = cur_seg;
    end
  end

  always_ff @(posedge clk or negedge r_n) begin
    if (!r_n) begin
      pre_q  <= '0;
      idx_q  <= '0;
      // NOTE: the snapshot is reset as well, so the first frame shows a defined 0 rather than X.
      snap_q <= '0;
      an_q   <= '1;
      seg_q  <= SEG_BLANK;
    end else begin
      // NOTE: use non-blocking assignments here so every flop samples values from before the edge.
      pre_q  <= pre_d;
      idx_q  <= idx_d;
      snap_q <= snap_d;
      an_q   <= an_d;
      seg_q  <= seg_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a frame-position reference model queues expected outputs.
// An independent negedge monitor compares the DUT outputs against that queue.
module tb_seg7_scan_display;

  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;
  localparam int FRAME    = DIGITS * SCAN_DIV;

  logic        clk = 1'b0;
  logic        r_n;
  logic        en;
  logic        blank_lz;
  logic [15:0] data;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        frame_done;

  always #5 clk = ~clk;

  seg7_scan_display #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk        (clk),
    .r_n        (r_n),
    .en         (en),
    .blank_lz   (blank_lz),
    .data       (data),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       fd;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_x;
  int          n_cmp  = 0;
  int          n_bad  = 0;
  int          phase;      // enabled cycles into the current frame
  logic [15:0] snap;       // digits the display is currently showing

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [6:0] ref_seg(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b0111111;
    endcase
  endfunction

  function automatic exp_t ref_out(input logic e, input logic blz, input int ph, input logic [15:0] s);
    exp_t r;
    int   idx;
    idx   = ph / SCAN_DIV;
    r.an  = 4'hF;
    r.seg = 7'h7F;
    r.fd  = 1'b0;
    if (!e) return r;
    if (blz && idx > 0 && (s >> (4 * idx)) == 16'd0) return r;
    r.an  = ~(4'b0001 << idx);
    r.seg = ref_seg(int'((s >> (4 * idx)) & 16'h000F));
    return r;
  endfunction

  // Each cycle: predict what the output registers capture at this edge, advance the model, then drive the new inputs.
  task automatic cycle(input logic e, input logic blz, input logic [15:0] d);
    exp_t x;
    @(posedge clk);
    x = ref_out(en, blank_lz, phase, snap);
    if (en) begin
      if (phase == FRAME - 1) snap = data;
      phase = (phase + 1) % FRAME;
    end
    #1;
    en       = e;
    blank_lz = blz;
    data     = d;
    x.fd     = en && (phase == FRAME - 1);
    sb_q.push_back(x);
  endtask

  function automatic logic [15:0] rand_data();
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
    end
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_an"}, 32'(an), 32'h0000_000F);
    check({tag, "_seg"}, 32'(seg), 32'h0000_007F);
    check({tag, "_frame_done"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        mon_x = sb_q.pop_front();
        check("an", 32'(an), 32'(mon_x.an));
        check("seg", 32'(seg), 32'(mon_x.seg));
        check("frame_done", 32'(frame_done), 32'(mon_x.fd));
      end
    end
  end

  initial begin
    logic [15:0] rd;
    r_n      = 1'b0;
    en       = 1'b0;
    blank_lz = 1'b0;
    data     = 16'h0000;
    phase    = 0;
    snap     = 16'h0000;
    #12;
    check_reset_outputs("por");

    // The first frame shows the reset snapshot (0000); 1234 appears after the first wrap.
    en   = 1'b1;
    data = 16'h1234;
    @(negedge clk);
    #1 r_n = 1'b1;
    repeat (3 * FRAME) cycle(1'b1, 1'b0, 16'h1234);

    repeat (2 * FRAME) cycle(1'b1, 1'b1, 16'h0070);
    repeat (2 * FRAME) cycle(1'b1, 1'b1, 16'h0A00);

    // Pause for 5 cycles in the middle of the digit-1 slot.
    while (phase != SCAN_DIV + 1) cycle(1'b1, 1'b0, 16'h4321);
    repeat (5) cycle(1'b0, 1'b0, 16'h4321);
    repeat (2 * FRAME) cycle(1'b1, 1'b0, 16'h4321);

    // Change the data mid-frame; the rest of the frame must keep showing 1234.
    repeat (FRAME) cycle(1'b1, 1'b0, 16'h1234);
    while (phase != 2 * SCAN_DIV) cycle(1'b1, 1'b0, 16'h1234);
    repeat (2 * FRAME) cycle(1'b1, 1'b0, 16'h5678);

    rd = rand_data();
    repeat (600) begin
      if ($urandom_range(0, 7) == 0) rd = rand_data();
      cycle(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), rd);
    end

    // Asynchronous reset in the middle of a scan.
    @(negedge clk);
    #1 r_n = 1'b0;
    #1 check_reset_outputs("async_rst");
    @(posedge clk);
    #1 check_reset_outputs("held_rst");
    phase = 0;
    snap  = 16'h0000;
    @(negedge clk);
    #1 r_n = 1'b1;
    repeat (300) begin
      if ($urandom_range(0, 7) == 0) rd = rand_data();
      cycle(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), rd);
    end

    @(negedge clk);
    #1 check("queue_drained", 32'(sb_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
